// File: rtl/enemy_pkg.sv
// enemy_pkg: shared types and constants for the enemy manager.
//   enemy_type_t     2-bit enemy type (selects speed)
//   CX_DEFAULT/CY_DEFAULT  default player centre
//   ring_x/ring_y    16-entry spawn ring, index 0 = top, clockwise
//   type_speed       type -> pixels moved per frame
package enemy_pkg;

  typedef logic [1:0] enemy_type_t;

  localparam int unsigned CX_DEFAULT = 320;
  localparam int unsigned CY_DEFAULT = 340;
  localparam int unsigned RING_W     = 10;

  function automatic logic [RING_W-1:0] ring_x(input logic [3:0] idx);
    case (idx)
      4'd0:    ring_x = 10'd320;
      4'd1:    ring_x = 10'd385;
      4'd2:    ring_x = 10'd448;
      4'd3:    ring_x = 10'd495;
      4'd4:    ring_x = 10'd521;
      4'd5:    ring_x = 10'd521;
      4'd6:    ring_x = 10'd495;
      4'd7:    ring_x = 10'd448;
      4'd8:    ring_x = 10'd385;
      4'd9:    ring_x = 10'd320;
      4'd10:   ring_x = 10'd255;
      4'd11:   ring_x = 10'd192;
      4'd12:   ring_x = 10'd145;
      4'd13:   ring_x = 10'd119;
      4'd14:   ring_x = 10'd119;
      4'd15:   ring_x = 10'd145;
      default: ring_x = 10'd320;
    endcase
  endfunction

  function automatic logic [RING_W-1:0] ring_y(input logic [3:0] idx);
    case (idx)
      4'd0:    ring_y = 10'd0;
      4'd1:    ring_y = 10'd48;
      4'd2:    ring_y = 10'd117;
      4'd3:    ring_y = 10'd200;
      4'd4:    ring_y = 10'd295;
      4'd5:    ring_y = 10'd385;
      4'd6:    ring_y = 10'd480;
      4'd7:    ring_y = 10'd563;
      4'd8:    ring_y = 10'd632;
      4'd9:    ring_y = 10'd680;
      4'd10:   ring_y = 10'd632;
      4'd11:   ring_y = 10'd563;
      4'd12:   ring_y = 10'd480;
      4'd13:   ring_y = 10'd385;
      4'd14:   ring_y = 10'd295;
      4'd15:   ring_y = 10'd200;
      default: ring_y = 10'd0;
    endcase
  endfunction

  function automatic logic [2:0] type_speed(input enemy_type_t t);
    case (t)
      2'd0:    type_speed = 3'd1;
      2'd1:    type_speed = 3'd2;
      2'd2:    type_speed = 3'd3;
      2'd3:    type_speed = 3'd4;
      default: type_speed = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/enemy_step_axis.sv
// enemy_step_axis: moves one coordinate toward its centre by at most speed_i.
//   coord_i   current coordinate
//   centre_i  target coordinate
//   speed_i   step size in pixels
//   coord_o   next coordinate (never overshoots the centre, never wraps)
module enemy_step_axis #(
  parameter int unsigned W = 11
) (
  input  logic [W-1:0] coord_i,
  input  logic [W-1:0] centre_i,
  input  logic [2:0]   speed_i,
  output logic [W-1:0] coord_o
);

  logic [W-1:0] spd_s;

  assign spd_s = W'(speed_i);

  // Compare first, subtract second: the difference is always taken big-minus-small.
  always_comb begin
    coord_o = coord_i;
    if (coord_i > centre_i) begin
      if ((coord_i - centre_i) > spd_s) begin
        coord_o = coord_i - spd_s;
      end else begin
        coord_o = centre_i;
      end
    end else if (coord_i < centre_i) begin
      if ((centre_i - coord_i) > spd_s) begin
        coord_o = coord_i + spd_s;
      end else begin
        coord_o = centre_i;
      end
    end else begin
      coord_o = coord_i;
    end
  end

endmodule

// File: rtl/enemy_spawner.sv
// enemy_spawner: multi-slot enemy manager.
//   clk, rst            clock, synchronous active-high reset
//   enable              gates spawning and movement (kills always accepted)
//   frame_tick          one pulse per video frame
//   spawn_angle/type    random ring index and enemy type, sampled on attempts
//   kill_valid/idx      kill request from hit detection
//   enemy_active/x/y/type  per-slot state, slot 0 in the LSBs
//   kill_ack, player_hit, hit_count, spawn_drop  registered one-cycle pulses
module enemy_spawner
  import enemy_pkg::*;
#(
  parameter int unsigned N_SLOTS      = 4,
  parameter int unsigned COORD_W      = 11,
  parameter int unsigned SPAWN_PERIOD = 60,
  parameter int unsigned CX           = CX_DEFAULT,
  parameter int unsigned CY           = CY_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_tick,
  input  logic [3:0]               spawn_angle,
  input  logic [1:0]               spawn_type,
  input  logic                     kill_valid,
  input  logic [2:0]               kill_idx,
  output logic [N_SLOTS-1:0]       enemy_active,
  output logic [N_SLOTS*COORD_W-1:0] enemy_x,
  output logic [N_SLOTS*COORD_W-1:0] enemy_y,
  output logic [N_SLOTS*2-1:0]     enemy_type,
  output logic                     kill_ack,
  output logic                     player_hit,
  output logic [3:0]               hit_count,
  output logic                     spawn_drop
);

  localparam int unsigned CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [COORD_W-1:0] CX_C     = COORD_W'(CX);
  localparam logic [COORD_W-1:0] CY_C     = COORD_W'(CY);

  logic [N_SLOTS-1:0] active_q, active_d;
  logic [COORD_W-1:0] x_q [N_SLOTS];
  logic [COORD_W-1:0] x_d [N_SLOTS];
  logic [COORD_W-1:0] y_q [N_SLOTS];
  logic [COORD_W-1:0] y_d [N_SLOTS];
  enemy_type_t        type_q [N_SLOTS];
  enemy_type_t        type_d [N_SLOTS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic       kill_ack_q, kill_ack_d;
  logic       player_hit_q, player_hit_d;
  logic [3:0] hit_count_q, hit_count_d;
  logic       spawn_drop_q, spawn_drop_d;

  logic [COORD_W-1:0] step_x_s [N_SLOTS];
  logic [COORD_W-1:0] step_y_s [N_SLOTS];
  logic [2:0]         speed_s  [N_SLOTS];
  logic [N_SLOTS-1:0] kill_hit_s;
  logic [N_SLOTS-1:0] arrive_s;
  logic               tick_s;
  logic               attempt_s;
  logic               free_found_s;
  logic [2:0]         free_idx_s;

  assign tick_s    = frame_tick & enable;
  assign attempt_s = tick_s & (cnt_q == CNT_LAST);

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    assign speed_s[g] = type_speed(type_q[g]);

    enemy_step_axis #(.W(COORD_W)) u_step_x (
      .coord_i  (x_q[g]),
      .centre_i (CX_C),
      .speed_i  (speed_s[g]),
      .coord_o  (step_x_s[g])
    );

    enemy_step_axis #(.W(COORD_W)) u_step_y (
      .coord_i  (y_q[g]),
      .centre_i (CY_C),
      .speed_i  (speed_s[g]),
      .coord_o  (step_y_s[g])
    );

    // Comparing against the slot number also rejects out-of-range indices.
    assign kill_hit_s[g] = kill_valid & (kill_idx == 3'(g)) & active_q[g];
    // A slot killed in its arrival cycle counts as a kill only.
    assign arrive_s[g]   = tick_s & active_q[g] & ~kill_hit_s[g] &
                           (step_x_s[g] == CX_C) & (step_y_s[g] == CY_C);

    assign enemy_x[g*COORD_W +: COORD_W] = x_q[g];
    assign enemy_y[g*COORD_W +: COORD_W] = y_q[g];
    assign enemy_type[g*2 +: 2]          = type_q[g];
  end

  assign enemy_active = active_q;
  assign kill_ack     = kill_ack_q;
  assign player_hit   = player_hit_q;
  assign hit_count    = hit_count_q;
  assign spawn_drop   = spawn_drop_q;

  // Lowest inactive slot at the start of the cycle; scanning downward lets the lowest win.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = 3'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = 3'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Next slot state, spawn counter and pulse values.
  always_comb begin
    active_d = active_q & ~kill_hit_s & ~arrive_s;
    if (tick_s) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    hit_count_d = 4'd0;
    for (int i = 0; i < N_SLOTS; i++) begin
      x_d[i]    = x_q[i];
      y_d[i]    = y_q[i];
      type_d[i] = type_q[i];
      hit_count_d = hit_count_d + {3'b000, arrive_s[i]};
      if (tick_s && active_q[i]) begin
        x_d[i] = step_x_s[i];
        y_d[i] = step_y_s[i];
      end else begin
        x_d[i] = x_q[i];
      end
      // The free slot was inactive, so it never also moves this cycle.
      if (attempt_s && free_found_s && (free_idx_s == 3'(i))) begin
        active_d[i] = 1'b1;
        x_d[i]      = COORD_W'(ring_x(spawn_angle));
        y_d[i]      = COORD_W'(ring_y(spawn_angle));
        type_d[i]   = spawn_type;
      end else begin
        type_d[i] = type_d[i];
      end
    end
    kill_ack_d   = |kill_hit_s;
    player_hit_d = |arrive_s;
    spawn_drop_d = attempt_s & ~free_found_s;
  end

  // State and pulse registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q     <= '0;
      cnt_q        <= '0;
      kill_ack_q   <= 1'b0;
      player_hit_q <= 1'b0;
      hit_count_q  <= 4'd0;
      spawn_drop_q <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        type_q[i] <= 2'd0;
      end
    end else begin
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      kill_ack_q   <= kill_ack_d;
      player_hit_q <= player_hit_d;
      hit_count_q  <= hit_count_d;
      spawn_drop_q <= spawn_drop_d;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        type_q[i] <= type_d[i];
      end
    end
  end

endmodule

// File: tb/tb_enemy_spawner.sv
module tb_enemy_spawner;

  localparam int N   = 4;
  localparam int W   = 11;
  localparam int P   = 2;
  localparam int CXV = 320;
  localparam int CYV = 340;

  logic clk = 1'b0;
  logic rst, enable, frame_tick, kill_valid;
  logic [3:0] spawn_angle;
  logic [1:0] spawn_type;
  logic [2:0] kill_idx;
  logic [N-1:0]   enemy_active;
  logic [N*W-1:0] enemy_x, enemy_y;
  logic [N*2-1:0] enemy_type;
  logic kill_ack, player_hit, spawn_drop;
  logic [3:0] hit_count;

  always #5 clk = ~clk;

  enemy_spawner #(.N_SLOTS(N), .COORD_W(W), .SPAWN_PERIOD(P), .CX(CXV), .CY(CYV)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .spawn_angle(spawn_angle), .spawn_type(spawn_type),
    .kill_valid(kill_valid), .kill_idx(kill_idx),
    .enemy_active(enemy_active), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .enemy_type(enemy_type), .kill_ack(kill_ack), .player_hit(player_hit),
    .hit_count(hit_count), .spawn_drop(spawn_drop)
  );

  int ring_x[16] = '{320,385,448,495,521,521,495,448,385,320,255,192,145,119,119,145};
  int ring_y[16] = '{0,48,117,200,295,385,480,563,632,680,632,563,480,385,295,200};

  // Reference model state
  int m_act[N], m_x[N], m_y[N], m_typ[N];
  int m_cnt;
  int e_ack, e_hit, e_hc, e_drop;
  int n_checks = 0;
  int n_fail = 0;

  function automatic int approach(int c, int t, int s);
    int d;
    d = t - c;
    if (d > s) d = s;
    if (d < -s) d = -s;
    return c + d;
  endfunction

  function automatic int sx(int i); return int'(enemy_x[i*W +: W]); endfunction
  function automatic int sy(int i); return int'(enemy_y[i*W +: W]); endfunction
  function automatic int st(int i); return int'(enemy_type[i*2 +: 2]); endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int nact[N], nx[N], ny[N], nt[N];
    int free_s, arrivals;
    bit tick, attempt, kill_ok;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_typ[i] = 0; end
      m_cnt = 0; e_ack = 0; e_hit = 0; e_hc = 0; e_drop = 0;
      return;
    end
    tick = frame_tick && enable;
    attempt = tick && (m_cnt == P - 1);
    if (tick) m_cnt = attempt ? 0 : m_cnt + 1;
    free_s = -1;
    for (int i = 0; i < N; i++) if (m_act[i] == 0 && free_s < 0) free_s = i;
    kill_ok = kill_valid && (int'(kill_idx) < N) && (m_act[kill_idx] != 0);
    arrivals = 0;
    for (int i = 0; i < N; i++) begin
      nact[i] = m_act[i]; nx[i] = m_x[i]; ny[i] = m_y[i]; nt[i] = m_typ[i];
      if (m_act[i] != 0 && tick) begin
        nx[i] = approach(m_x[i], CXV, m_typ[i] + 1);
        ny[i] = approach(m_y[i], CYV, m_typ[i] + 1);
        if (nx[i] == CXV && ny[i] == CYV) begin
          nact[i] = 0;
          if (!(kill_ok && int'(kill_idx) == i)) arrivals++;
        end
      end
    end
    if (kill_ok) nact[kill_idx] = 0;
    if (attempt && free_s >= 0) begin
      nact[free_s] = 1; nx[free_s] = ring_x[spawn_angle];
      ny[free_s] = ring_y[spawn_angle]; nt[free_s] = int'(spawn_type);
    end
    e_drop = (attempt && free_s < 0) ? 1 : 0;
    e_ack  = kill_ok ? 1 : 0;
    e_hc   = arrivals;
    e_hit  = (arrivals > 0) ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      m_act[i] = nact[i]; m_x[i] = nx[i]; m_y[i] = ny[i]; m_typ[i] = nt[i];
    end
  endtask

  task automatic compare_all();
    logic [31:0] ea;
    ea = 0;
    for (int i = 0; i < N; i++) ea[i] = (m_act[i] != 0);
    check("active", 32'(enemy_active), ea);
    for (int i = 0; i < N; i++) begin
      if (m_act[i] != 0) begin
        check($sformatf("x%0d", i), sx(i), m_x[i]);
        check($sformatf("y%0d", i), sy(i), m_y[i]);
        check($sformatf("type%0d", i), st(i), m_typ[i]);
      end
    end
    check("kill_ack", 32'(kill_ack), e_ack);
    check("player_hit", 32'(player_hit), e_hit);
    check("hit_count", 32'(hit_count), e_hc);
    check("spawn_drop", 32'(spawn_drop), e_drop);
  endtask

  task automatic drive(input bit r, input bit en, input bit ft, input int ang, input int typ,
                       input bit kv, input int ki);
    rst = r; enable = en; frame_tick = ft;
    spawn_angle = 4'(ang); spawn_type = 2'(typ);
    kill_valid = kv; kill_idx = 3'(ki);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic tick(input int ang, input int typ);
    drive(1'b0, 1'b1, 1'b1, ang, typ, 1'b0, 0);
    cyc();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b1, 5, 2, 1'b1, 0);
    cyc();
    cyc();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 32'(enemy_active), 0);
    check({tag, "_x"}, enemy_x, 0);
    check({tag, "_y"}, enemy_y, 0);
    check({tag, "_type"}, 32'(enemy_type), 0);
    check({tag, "_pulses"}, {28'd0, kill_ack, player_hit, spawn_drop, 1'b0}, 0);
    check({tag, "_hit_count"}, 32'(hit_count), 0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Top spawn, fastest type, straight down to the centre
    tick(0, 3); tick(0, 3);
    check("s1_spawn_active0", 32'(enemy_active[0]), 1);
    check("s1_spawn_x", sx(0), 320);
    check("s1_spawn_y", sy(0), 0);
    tick(0, 3);
    check("s1_first_step_y", sy(0), 4);
    check("s1_first_step_x", sx(0), 320);
    repeat (83) tick(0, 3);
    check("s1_before_arrival_y", sy(0), 336);
    tick(0, 3);
    check("s1_arrival_hit", 32'(player_hit), 1);
    check("s1_arrival_count", 32'(hit_count), 1);
    check("s1_arrival_inactive", 32'(enemy_active[0]), 0);

    // Angle 4, slowest type: diagonal then horizontal
    do_reset();
    tick(4, 0); tick(4, 0);
    check("s2_spawn_x", sx(0), 521);
    check("s2_spawn_y", sy(0), 295);
    repeat (45) tick(4, 0);
    check("s2_corner_x", sx(0), 476);
    check("s2_corner_y", sy(0), 340);
    repeat (155) tick(4, 0);
    check("s2_last_x", sx(0), 321);
    check("s2_last_y", sy(0), 340);
    tick(4, 0);
    check("s2_arrival_hit", 32'(player_hit), 1);
    check("s2_arrival_inactive", 32'(enemy_active[0]), 0);

    // Fill all slots, then the next attempt drops
    do_reset();
    repeat (8) tick(9, 0);
    check("s3_full", 32'(enemy_active), 32'hF);
    tick(9, 0);
    check("s3_no_attempt_drop", 32'(spawn_drop), 0);
    tick(9, 0);
    check("s3_drop", 32'(spawn_drop), 1);
    check("s3_full_kept", 32'(enemy_active), 32'hF);

    // Kills: live slot, dead slot, out-of-range index, with enable low
    drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 2); cyc();
    check("s4_kill_ack", 32'(kill_ack), 1);
    check("s4_kill_active", 32'(enemy_active), 32'hB);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 2); cyc();
    check("s4_dead_no_ack", 32'(kill_ack), 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 5); cyc();
    check("s4_range_no_ack", 32'(kill_ack), 0);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 3); cyc();
    check("s4_disabled_kill_ack", 32'(kill_ack), 1);
    check("s4_disabled_active", 32'(enemy_active), 32'h3);

    // Two slots arriving on the same tick
    do_reset();
    tick(2, 2); tick(2, 2);
    tick(1, 3); tick(1, 3);
    repeat (72) tick(9, 0);
    tick(9, 0);
    check("s5_double_hit", 32'(player_hit), 1);
    check("s5_double_count", 32'(hit_count), 2);
    check("s5_double_inactive", 32'(enemy_active[1:0]), 0);

    // Kill wins over arrival
    do_reset();
    tick(0, 3); tick(0, 3);
    repeat (84) tick(9, 0);
    drive(1'b0, 1'b1, 1'b1, 9, 0, 1'b1, 0); cyc();
    check("s5_kill_arrive_ack", 32'(kill_ack), 1);
    check("s5_kill_arrive_hit", 32'(player_hit), 0);
    check("s5_kill_arrive_inactive", 32'(enemy_active[0]), 0);

    // Spawn alongside a kill of slot 0 goes to slot 1; then reset mid-motion
    do_reset();
    tick(0, 3); tick(0, 3); tick(0, 3);
    drive(1'b0, 1'b1, 1'b1, 5, 1, 1'b1, 0); cyc();
    check("s6_spawn_slot1", 32'(enemy_active), 32'h2);
    check("s6_spawn_x", sx(1), 521);
    check("s6_spawn_y", sy(1), 385);
    check("s6_spawn_type", st(1), 1);
    repeat (5) tick(7, 2);
    drive(1'b1, 1'b1, 1'b1, 3, 3, 1'b1, 1); cyc();
    check_all_zero("midreset");

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      drive(($urandom_range(0, 1999) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0),
            int'($urandom_range(0, 7)));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_spawner.md
Name: enemy_spawner

Overview:
- Multi-slot enemy manager; successor to the combinational 16-angle spawn-position lookup.
- Holds up to N_SLOTS live enemies. Spawns them on a frame-tick schedule at one of 16 ring positions chosen by a random angle input. Moves each enemy toward the player centre every frame.
- Retires enemies on kill requests from the hit-detection logic, or when they reach the centre (player damage).
- Sits between the LFSR/random source and the VGA sprite renderer / score logic.

Parameters:
- N_SLOTS, 4, number of concurrent enemy slots (1..8)
- COORD_W, 11, coordinate width in bits
- SPAWN_PERIOD, 60, frame ticks between spawn attempts (>=1)
- CX, 320, player centre x
- CY, 340, player centre y

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  gates spawning and movement; kills are still accepted
- frame_tick  in  1  one-cycle pulse per video frame
- spawn_angle  in  4  random ring index (0 = top, clockwise)
- spawn_type  in  2  random enemy type; selects speed
- kill_valid  in  1  kill request strobe
- kill_idx  in  3  slot to kill
- enemy_active  out  N_SLOTS  per-slot live flag
- enemy_x  out  N_SLOTS*COORD_W  packed x positions; slot 0 in the LSBs
- enemy_y  out  N_SLOTS*COORD_W  packed y positions
- enemy_type  out  N_SLOTS*2  packed types
- kill_ack  out  1  pulse: kill hit a live slot
- player_hit  out  1  pulse: one or more enemies reached the centre
- hit_count  out  4  number of arrivals in that cycle
- spawn_drop  out  1  pulse: spawn attempt found no free slot

Behaviour:
- Reset:
  - All outputs are 0, and all slot x/y/type registers are 0.
  - The spawn counter is 0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-operation clears all slots immediately.
- Spawn counter:
  - Increments on frame_tick && enable.
  - When it equals SPAWN_PERIOD-1 on such a tick, a spawn attempt occurs and the counter returns to 0.
  - With SPAWN_PERIOD=1, every enabled tick is an attempt.
- Spawn slot selection:
  - Target is the lowest-index slot that is inactive at the start of the cycle.
  - A slot killed or retired in the same cycle is not reused until a later attempt.
  - The slot loads x,y from the ring table indexed by spawn_angle, and type from spawn_type. Both are sampled in the attempt cycle.
  - Active is asserted at the next edge.
  - A newly spawned enemy does not move in its spawn cycle.
- Ring table (x,y), index 0..15: (320,0) (385,48) (448,117) (495,200) (521,295) (521,385) (495,480) (448,563) (385,632) (320,680) (255,632) (192,563) (145,480) (119,385) (119,295) (145,200).
- Full: if no free slot, the attempt is discarded and spawn_drop pulses for 1 cycle. The counter still resets.
- Movement, on frame_tick && enable, for each slot active at the start of the cycle:
  - Speed by type: 0→1, 1→2, 2→3, 3→4 px/frame.
  - Each axis moves independently toward its centre by min(speed, |coord − centre|).
  - Use unsigned compare-then-subtract; a coordinate never overshoots or wraps.
- Arrival:
  - Evaluated on the post-step position.
  - If x==CX and y==CY, the slot goes inactive at the same edge.
  - player_hit pulses 1 cycle; hit_count = number of slots arriving that cycle.
- Kill:
  - If kill_valid and kill_idx < N_SLOTS and that slot is active, the slot is cleared next edge and kill_ack pulses 1 cycle.
  - An inactive or out-of-range index is ignored: no ack.
  - Kill and arrival on the same slot in the same cycle: kill wins. kill_ack=1, and that slot is not counted in hit_count or player_hit.
- Pulses: all pulse outputs are registered, 1-cycle latency from the causing cycle, and are 0 otherwise.
- Inactive slots hold their last x/y/type. The renderer must qualify them with enemy_active.
- enable=0: counter frozen, no movement, no spawn; kills still accepted.

Decomposition:
- Package enemy_pkg holds:
  - the 16-entry ring position constant table;
  - the type-to-speed function;
  - CX/CY defaults;
  - the enemy_type_t 2-bit typedef.
- One natural sub-module, enemy_step_axis (combinational): inputs current coord, centre, speed; outputs the next coord. It is instantiated twice per slot.

Test Plan:
- Reset, then enable with SPAWN_PERIOD=2, angle=0, type=3 → after the 2nd tick, slot0 is active at (320,0). Each later tick: y += 4, x stays 320. Slot0 arrives after 85 ticks → player_hit=1, hit_count=1, slot0 inactive.
- Angle=4 (521,295), type=0 → per tick x−1 and y+1 until y=340 (45 ticks). Then x only until 320: total 201 ticks, no overshoot.
- N_SLOTS=4, SPAWN_PERIOD=1, slow type, 5 ticks → slots 0–3 active. The 5th attempt gives spawn_drop=1 and the slots are unchanged.
- Kill slot 2 while active → kill_ack=1 one cycle later and enemy_active[2]=0. Kill an inactive slot or kill_idx=5 → no ack.
- Kill slot 0 in the same cycle it would arrive → kill_ack=1, player_hit=0. Two other slots arriving the same tick → hit_count=2, single player_hit pulse.
- Spawn attempt in the same cycle slot 0 is killed, with slot 1 free → spawn lands in slot 1. Assert rst mid-motion → all outputs are 0 the next cycle.
